// File: rtl/pipe_pkg.sv
// Shared pipeline types: enable encoding, per-stage control structs and their bubbles.
// Bubble constants leave every write/jump/branch enable at DISABLE.
package pipe_pkg;

    typedef enum logic {
        DISABLE = 1'b0,
        ENABLE  = 1'b1
    } enable_t;

    typedef struct packed {
        enable_t    reg_we;
        enable_t    mem_re;
        enable_t    mem_we;
        enable_t    branch;
        enable_t    jump;
        logic [5:0] alu_op;
        logic [4:0] rd;
    } id_ex_ctrl_t;

    typedef struct packed {
        enable_t    reg_we;
        enable_t    mem_re;
        enable_t    mem_we;
        logic [2:0] mem_size;
        logic [4:0] rd;
    } ex_mem_ctrl_t;

    typedef struct packed {
        enable_t    reg_we;
        logic [1:0] wb_sel;
        logic [4:0] rd;
    } mem_wb_ctrl_t;

    localparam id_ex_ctrl_t ID_EX_CTRL_BUBBLE = '{
        reg_we: DISABLE, mem_re: DISABLE, mem_we: DISABLE,
        branch: DISABLE, jump: DISABLE, alu_op: '0, rd: '0
    };

    localparam ex_mem_ctrl_t EX_MEM_CTRL_BUBBLE = '{
        reg_we: DISABLE, mem_re: DISABLE, mem_we: DISABLE,
        mem_size: '0, rd: '0
    };

    localparam mem_wb_ctrl_t MEM_WB_CTRL_BUBBLE = '{
        reg_we: DISABLE, wb_sel: '0, rd: '0
    };

    function automatic logic [1:0] entry_count(input logic m_valid, input logic s_valid);
        return {1'b0, m_valid} + {1'b0, s_valid};
    endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// One {valid, data, ctrl} pipeline register. Clear beats load; clear keeps data
// and parks ctrl at CTRL_BUBBLE so an empty slot never shows live control.
module pipe_stage_slot
    import pipe_pkg::*;
#(
    parameter int                DATA_W      = 128,
    parameter int                CTRL_W      = 16,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o
);

    logic              valid_d, valid_q;
    logic [DATA_W-1:0] data_d,  data_q;
    logic [CTRL_W-1:0] ctrl_d,  ctrl_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        if (clear_i) begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_BUBBLE;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            ctrl_d  = ctrl_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= CTRL_BUBBLE;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline stage register with flush-to-bubble.
// Define PIPE_STAGE_SKID_EN to add a skid entry that registers ready_o.
module pipe_stage_hs
    import pipe_pkg::*;
#(
    parameter int                DATA_W      = 128,
    parameter int                CTRL_W      = 16,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_c_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [1:0]        count_o
);

    logic              accept, pop;
    logic              m_load, m_clear, m_valid;
    logic [DATA_W-1:0] m_data_in;
    logic [CTRL_W-1:0] m_ctrl_in;

`ifdef PIPE_STAGE_SKID_EN
    logic              s_load, s_clear, s_valid;
    logic [DATA_W-1:0] s_data;
    logic [CTRL_W-1:0] s_ctrl;

    // ready_o comes straight off the skid valid flop: no path from ready_i.
    always_comb begin
        pop       = m_valid && ready_i;
        ready_o   = !s_valid;
        accept    = valid_i && ready_o && !flush_c_i;
        m_load    = (pop && s_valid) || (accept && (!m_valid || pop));
        m_clear   = flush_c_i || (pop && !s_valid && !accept);
        s_load    = accept && m_valid && !pop;
        s_clear   = flush_c_i || (pop && s_valid);
        m_data_in = s_valid ? s_data : data_i;
        m_ctrl_in = s_valid ? s_ctrl : ctrl_i;
    end

    pipe_stage_slot #(
        .DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_BUBBLE(CTRL_BUBBLE)
    ) u_skid (
        .clk(clk), .rst(rst), .load_i(s_load), .clear_i(s_clear),
        .data_i(data_i), .ctrl_i(ctrl_i),
        .valid_o(s_valid), .data_o(s_data), .ctrl_o(s_ctrl)
    );

    assign count_o = entry_count(m_valid, s_valid);
`else
    always_comb begin
        pop       = m_valid && ready_i;
        ready_o   = ready_i || !m_valid;
        accept    = valid_i && ready_o && !flush_c_i;
        m_load    = accept;
        m_clear   = flush_c_i || (pop && !accept);
        m_data_in = data_i;
        m_ctrl_in = ctrl_i;
    end

    assign count_o = entry_count(m_valid, 1'b0);
`endif

    pipe_stage_slot #(
        .DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_BUBBLE(CTRL_BUBBLE)
    ) u_main (
        .clk(clk), .rst(rst), .load_i(m_load), .clear_i(m_clear),
        .data_i(m_data_in), .ctrl_i(m_ctrl_in),
        .valid_o(m_valid), .data_o(data_o), .ctrl_o(ctrl_o)
    );

    assign valid_o = m_valid;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: directed scenarios plus random traffic against a queue model.
// Honours PIPE_STAGE_SKID_EN the same way the design does.
module tb_pipe_stage_hs;
    import pipe_pkg::*;

    localparam int           DW  = 32;
    localparam int           CW  = 16;
    localparam logic [CW-1:0] BUB = 16'h0300;
`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush_c_i = 1'b0;
    logic          valid_i = 1'b0;
    logic          ready_i = 1'b0;
    logic [DW-1:0] data_i = '0;
    logic [CW-1:0] ctrl_i = '0;
    logic          ready_o, valid_o;
    logic [DW-1:0] data_o;
    logic [CW-1:0] ctrl_o;
    logic [1:0]    count_o;

    always #5 clk = ~clk;

    pipe_stage_hs #(.DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE(BUB)) dut (
        .clk(clk), .rst(rst), .flush_c_i(flush_c_i),
        .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i), .ctrl_i(ctrl_i),
        .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .ctrl_o(ctrl_o),
        .count_o(count_o)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO of held beats (capacity CAP) plus the last head data shown.
    logic [DW-1:0] mq_d[$];
    logic [CW-1:0] mq_c[$];
    logic [DW-1:0] shown = '0;

    typedef struct packed {
        logic          v;
        logic          r;
        logic [1:0]    c;
        logic [CW-1:0] ct;
        logic [DW-1:0] d;
    } obs_t;

    function automatic logic exp_ready();
        if (CAP == 2) return mq_d.size() < 2;
        return ready_i || (mq_d.size() == 0);
    endfunction

    function automatic obs_t exp_obs();
        obs_t o;
        o.v  = mq_d.size() > 0;
        o.r  = exp_ready();
        o.c  = 2'(mq_d.size());
        o.ct = (mq_d.size() > 0) ? mq_c[0] : BUB;
        o.d  = shown;
        return o;
    endfunction

    function automatic obs_t act_obs();
        return '{v: valid_o, r: ready_o, c: count_o, ct: ctrl_o, d: data_o};
    endfunction

    // Advance one clock edge and apply the same transfer to the model.
    task automatic tick();
        bit acc, pp;
        acc = valid_i && exp_ready() && !flush_c_i;
        pp  = (mq_d.size() > 0) && ready_i;
        @(posedge clk);
        if (rst) begin
            mq_d.delete(); mq_c.delete(); shown = '0;
        end else if (flush_c_i) begin
            mq_d.delete(); mq_c.delete();
        end else begin
            if (pp) begin void'(mq_d.pop_front()); void'(mq_c.pop_front()); end
            if (acc) begin mq_d.push_back(data_i); mq_c.push_back(ctrl_i); end
            if (mq_d.size() > 0) shown = mq_d[0];
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid_i = 1'b1; ctrl_i = 16'hFFFF; data_i = 32'hDEAD_BEEF; ready_i = 1'b0;
        tick(); tick();
        checks++;
        if ({valid_o, ready_o, count_o, ctrl_o, data_o} !== {1'b1 ^ 1'b1, 1'b1, 2'd0, BUB, 32'h0}) begin
            errors++;
            $display("FAIL reset_state got v=%0b r=%0b c=%0d ct=%h d=%h want v=0 r=1 c=0 ct=%h d=0",
                     valid_o, ready_o, count_o, ctrl_o, data_o, BUB);
        end
        rst = 1'b0; data_i = 32'h55; ctrl_i = 16'h1234;
        #1;
        checks++;
        if (ready_o !== 1'b1) begin
            errors++; $display("FAIL reset_ready_after got %0b want 1", ready_o);
        end
        tick();
        checks++;
        if ({valid_o, data_o, ctrl_o, count_o} !== {1'b1, 32'h55, 16'h1234, 2'd1}) begin
            errors++;
            $display("FAIL reset_first_beat got v=%0b d=%h ct=%h c=%0d want v=1 d=55 ct=1234 c=1",
                     valid_o, data_o, ctrl_o, count_o);
        end
        valid_i = 1'b0; ready_i = 1'b1;
        tick();
        checks++;
        if ({valid_o, ctrl_o, data_o} !== {1'b0, BUB, 32'h55}) begin
            errors++;
            $display("FAIL pop_to_bubble got v=%0b ct=%h d=%h want v=0 ct=%h d=55", valid_o, ctrl_o, data_o, BUB);
        end
    endtask

    task automatic test_streaming();
        logic [CW-1:0] c;
        ready_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            c = CW'($urandom);
            valid_i = 1'b1; data_i = DW'(i); ctrl_i = c;
            tick();
            checks++;
            if ({valid_o, data_o, ctrl_o} !== {1'b1, DW'(i), c}) begin
                errors++;
                $display("FAIL stream_beat%0d got v=%0b d=%0d ct=%h want v=1 d=%0d ct=%h",
                         i, valid_o, data_o, ctrl_o, i, c);
            end
        end
        valid_i = 1'b0;
        tick();
        checks++;
        if ({valid_o, count_o} !== {1'b0, 2'd0}) begin
            errors++; $display("FAIL stream_drain got v=%0b c=%0d want v=0 c=0", valid_o, count_o);
        end
    endtask

`ifndef PIPE_STAGE_SKID_EN
    task automatic test_backpressure();
        ready_i = 1'b1; valid_i = 1'b1; data_i = 32'hA; ctrl_i = 16'h00A0;
        tick();
        ready_i = 1'b0; data_i = 32'hB; ctrl_i = 16'h00B0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if ({ready_o, valid_o, data_o} !== {1'b0, 1'b1, 32'hA}) begin
                errors++;
                $display("FAIL bp_hold%0d got r=%0b v=%0b d=%h want r=0 v=1 d=a", k, ready_o, valid_o, data_o);
            end
            tick();
        end
        ready_i = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b1) begin
            errors++; $display("FAIL bp_ready_return got %0b want 1", ready_o);
        end
        tick();
        checks++;
        if ({valid_o, data_o, ctrl_o} !== {1'b1, 32'hB, 16'h00B0}) begin
            errors++;
            $display("FAIL bp_beat_b got v=%0b d=%h ct=%h want v=1 d=b ct=00b0", valid_o, data_o, ctrl_o);
        end
        valid_i = 1'b0;
        tick();
    endtask
`endif

    task automatic test_flush();
        ready_i = 1'b0; valid_i = 1'b1; data_i = 32'hA1; ctrl_i = 16'h0A11;
        tick();
        data_i = 32'hB2; ctrl_i = 16'h0B22; flush_c_i = 1'b1; ready_i = 1'b1;
        tick();
        flush_c_i = 1'b0; valid_i = 1'b0;
        checks++;
        if ({valid_o, ctrl_o, count_o, data_o} !== {1'b0, BUB, 2'd0, 32'hA1}) begin
            errors++;
            $display("FAIL flush_state got v=%0b ct=%h c=%0d d=%h want v=0 ct=%h c=0 d=a1",
                     valid_o, ctrl_o, count_o, data_o, BUB);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (valid_o !== 1'b0) begin
                errors++; $display("FAIL flush_no_ghost%0d got v=%0b d=%h want v=0", k, valid_o, data_o);
            end
        end
    endtask

`ifdef PIPE_STAGE_SKID_EN
    task automatic test_skid();
        ready_i = 1'b0; valid_i = 1'b1; data_i = 32'hA; ctrl_i = 16'h00A0;
        tick();
        data_i = 32'hB; ctrl_i = 16'h00B0;
        tick();
        valid_i = 1'b0;
        checks++;
        if ({count_o, ready_o, data_o} !== {2'd2, 1'b0, 32'hA}) begin
            errors++;
            $display("FAIL skid_full got c=%0d r=%0b d=%h want c=2 r=0 d=a", count_o, ready_o, data_o);
        end
        ready_i = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b0) begin
            errors++; $display("FAIL skid_ready_registered got %0b want 0", ready_o);
        end
        tick();
        checks++;
        if ({valid_o, data_o, ctrl_o, count_o, ready_o} !== {1'b1, 32'hB, 16'h00B0, 2'd1, 1'b1}) begin
            errors++;
            $display("FAIL skid_drain_b got v=%0b d=%h ct=%h c=%0d r=%0b want v=1 d=b ct=00b0 c=1 r=1",
                     valid_o, data_o, ctrl_o, count_o, ready_o);
        end
        tick();
        checks++;
        if ({valid_o, count_o} !== {1'b0, 2'd0}) begin
            errors++; $display("FAIL skid_empty got v=%0b c=%0d want v=0 c=0", valid_o, count_o);
        end
    endtask

    task automatic test_skid_flush();
        ready_i = 1'b0; valid_i = 1'b1; data_i = 32'hC; ctrl_i = 16'h00C0;
        tick();
        data_i = 32'hD; ctrl_i = 16'h00D0;
        tick();
        checks++;
        if (count_o !== 2'd2) begin
            errors++; $display("FAIL skidflush_fill got c=%0d want 2", count_o);
        end
        ready_i = 1'b1; flush_c_i = 1'b1; data_i = 32'hE;
        tick();
        flush_c_i = 1'b0; valid_i = 1'b0;
        checks++;
        if ({valid_o, count_o, ready_o, ctrl_o} !== {1'b0, 2'd0, 1'b1, BUB}) begin
            errors++;
            $display("FAIL skidflush_state got v=%0b c=%0d r=%0b ct=%h want v=0 c=0 r=1 ct=%h",
                     valid_o, count_o, ready_o, ctrl_o, BUB);
        end
        tick();
        checks++;
        if (valid_o !== 1'b0) begin
            errors++; $display("FAIL skidflush_no_ghost got v=%0b d=%h want v=0", valid_o, data_o);
        end
    endtask
`endif

    task automatic test_random();
        obs_t e, a;
        bit   hold = 1'b0;
        bit   acc;
        for (int n = 0; n < 600; n++) begin
            if (!hold) begin
                valid_i = ($urandom_range(0, 3) != 0);
                data_i  = DW'($urandom);
                ctrl_i  = CW'($urandom);
            end
            ready_i   = ($urandom_range(0, 3) != 0);
            flush_c_i = ($urandom_range(0, 15) == 0);
            rst       = ($urandom_range(0, 63) == 0);
            #1;
            e = exp_obs();
            a = act_obs();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL random_cyc%0d got v=%0b r=%0b c=%0d ct=%h d=%h want v=%0b r=%0b c=%0d ct=%h d=%h",
                         n, a.v, a.r, a.c, a.ct, a.d, e.v, e.r, e.c, e.ct, e.d);
            end
            acc  = valid_i && exp_ready() && !flush_c_i && !rst;
            hold = valid_i && !acc && !flush_c_i && !rst;
            tick();
        end
        rst = 1'b0; flush_c_i = 1'b0; valid_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_streaming();
`ifndef PIPE_STAGE_SKID_EN
        test_backpressure();
`endif
        test_flush();
`ifdef PIPE_STAGE_SKID_EN
        test_skid();
        test_skid_flush();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
